// File: rtl/mem_seq_pkg.sv
// Shared types and control-field encodings for the memory micro-step sequencer.
package mem_seq_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_OPLO,
        ST_OPHI,
        ST_LINK,
        ST_JUMP,
        ST_RETJ,
        ST_PUSHW,
        ST_PUSHD,
        ST_POPI,
        ST_POPR,
        ST_HALT
    } state_e;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_CALL = 3'b010;
    localparam logic [2:0] OP_RET  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_HLT  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    localparam logic [2:0] ADDR_TX   = 3'd0;
    localparam logic [2:0] ADDR_SP   = 3'd3;
    localparam logic [2:0] ADDR_LR   = 3'd4;
    localparam logic [2:0] ADDR_PC   = 3'd5;
    localparam logic [2:0] ADDR_IDLE = 3'd7;

    localparam logic [3:0] OUT_MEM  = 4'h3;
    localparam logic [3:0] OUT_TXH  = 4'h5;
    localparam logic [3:0] OUT_TXL  = 4'hB;
    localparam logic [3:0] OUT_IDLE = 4'h7;

    localparam logic [3:0] LOAD_MEM  = 4'h3;
    localparam logic [3:0] LOAD_IR   = 4'h4;
    localparam logic [3:0] LOAD_TXH  = 4'h5;
    localparam logic [3:0] LOAD_TXL  = 4'hB;
    localparam logic [3:0] LOAD_IDLE = 4'h7;

    function automatic logic [3:0] gpr_code(input logic [2:0] r);
        return {1'b1, r};
    endfunction

endpackage

// File: rtl/mem_seq_ctrl_decode.sv
// Combinational state -> control-field decode for the memory block; no storage.
module mem_seq_decode
    import mem_seq_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic [2:0] r_i,
    output logic [2:0] addrout_o,
    output logic [2:0] addrload_o,
    output logic [3:0] outctl_o,
    output logic [3:0] loadctl_o,
    output logic       spinc_o,
    output logic       spdec_o
);

    always_comb begin
        addrout_o  = ADDR_IDLE;
        addrload_o = ADDR_IDLE;
        outctl_o   = OUT_IDLE;
        loadctl_o  = LOAD_IDLE;
        spinc_o    = 1'b1;
        spdec_o    = 1'b1;
        case (state_e'(state_i))
            ST_FETCH: begin
                addrout_o = ADDR_PC; outctl_o = OUT_MEM; loadctl_o = LOAD_IR;
            end
            ST_OPLO: begin
                addrout_o = ADDR_PC; outctl_o = OUT_MEM; loadctl_o = LOAD_TXL;
            end
            ST_OPHI: begin
                addrout_o = ADDR_PC; outctl_o = OUT_MEM; loadctl_o = LOAD_TXH;
            end
            // PC also increments here, so LR captures the address after the operand bytes
            ST_LINK: begin
                addrout_o = ADDR_PC; addrload_o = ADDR_LR;
            end
            ST_JUMP: begin
                addrout_o = ADDR_TX; addrload_o = ADDR_PC;
            end
            ST_RETJ: begin
                addrout_o = ADDR_LR; addrload_o = ADDR_PC;
            end
            ST_PUSHW: begin
                addrout_o = ADDR_SP; outctl_o = gpr_code(r_i); loadctl_o = LOAD_MEM;
            end
            ST_PUSHD: spdec_o = 1'b0;
            ST_POPI:  spinc_o = 1'b0;
            ST_POPR: begin
                addrout_o = ADDR_SP; outctl_o = OUT_MEM; loadctl_o = gpr_code(r_i);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_seq_ctrl.sv
// Moore micro-step sequencer: fetches opcodes into IR and steps them through
// 1-cycle micro-states driving the memory block's encoded control fields.
module mem_seq_ctrl
    import mem_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [7:0]       iout_i,
    input  logic             stall_i,
    input  logic             run_i,
    output logic [2:0]       addroutctl_o,
    output logic [2:0]       addrloadctl_o,
    output logic [3:0]       outctl_o,
    output logic [3:0]       loadctl_o,
    output logic             spinc_o,
    output logic             spdec_o,
    output logic             halted_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_count_o
);

    state_e           state_q, state_d;
    logic [2:0]       r_q, r_d;
    logic             call_q, call_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q;
    logic             bump;
    logic [2:0]       cls;
    logic             unused_iout;

    assign cls         = iout_i[7:5];
    assign unused_iout = ^iout_i[4:3];

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        call_d  = call_q;
        ill_d   = ill_q;
        if (!stall_i) begin
            case (state_q)
                ST_FETCH:  state_d = ST_DECODE;
                ST_DECODE: begin
                    r_d    = iout_i[2:0];
                    call_d = (cls == OP_CALL);
                    if (cls == OP_ILL) ill_d = 1'b1;
                    case (cls)
                        OP_JMP, OP_CALL: state_d = ST_OPLO;
                        OP_RET:          state_d = ST_RETJ;
                        // only r = 4..7 names a GPR; anything else retires as a NOP
                        OP_PUSH:         state_d = iout_i[2] ? ST_PUSHW : ST_FETCH;
                        OP_POP:          state_d = iout_i[2] ? ST_POPI : ST_FETCH;
                        OP_HLT:          state_d = ST_HALT;
                        default:         state_d = ST_FETCH;
                    endcase
                end
                ST_OPLO:  state_d = ST_OPHI;
                ST_OPHI:  state_d = call_q ? ST_LINK : ST_JUMP;
                ST_LINK:  state_d = ST_JUMP;
                ST_JUMP:  state_d = ST_FETCH;
                ST_RETJ:  state_d = ST_FETCH;
                ST_PUSHW: state_d = ST_PUSHD;
                ST_PUSHD: state_d = ST_FETCH;
                ST_POPI:  state_d = ST_POPR;
                ST_POPR:  state_d = ST_FETCH;
                ST_HALT:  if (run_i) state_d = ST_FETCH;
                default:  state_d = ST_FETCH;
            endcase
        end
    end

    // Retire on the final micro-step of each instruction; HALT -> FETCH is not a retirement
    assign bump = ((state_d == ST_FETCH) &&
                   (state_q inside {ST_DECODE, ST_JUMP, ST_RETJ, ST_PUSHD, ST_POPR})) ||
                  ((state_d == ST_HALT) && (state_q != ST_HALT));

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ST_FETCH;
            r_q     <= 3'd0;
            call_q  <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            call_q  <= call_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, bump};
        end
    end

    logic [2:0] dec_aout, dec_aload;
    logic [3:0] dec_out, dec_load;
    logic       dec_inc, dec_dec;

    mem_seq_decode u_decode (
        .state_i    (state_q),
        .r_i        (r_q),
        .addrout_o  (dec_aout),
        .addrload_o (dec_aload),
        .outctl_o   (dec_out),
        .loadctl_o  (dec_load),
        .spinc_o    (dec_inc),
        .spdec_o    (dec_dec)
    );

    // Stall and reset both hold the memory block still: no PC or SP side effects
    logic idle;
    assign idle = stall_i | ~rstn_i;

    assign addroutctl_o  = idle ? ADDR_IDLE : dec_aout;
    assign addrloadctl_o = idle ? ADDR_IDLE : dec_aload;
    assign outctl_o      = idle ? OUT_IDLE  : dec_out;
    assign loadctl_o     = idle ? LOAD_IDLE : dec_load;
    assign spinc_o       = idle | dec_inc;
    assign spdec_o       = idle | dec_dec;
    assign halted_o      = (state_q == ST_HALT);
    assign illegal_o     = ill_q;
    assign instr_count_o = cnt_q;

endmodule
